// File: rtl/ov5640_wr_arbiter.sv
// Two-channel camera write arbiter: round-robin grant of full bursts from
// two line FIFOs onto a single burst-command / write-beat interface, with
// per-channel frame offset tracking and frame-start realignment.
module ov5640_wr_arbiter #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned CH0_BASE    = 0,
    parameter int unsigned CH1_BASE    = 'h0100000,
    parameter int unsigned FRAME_WORDS = 'h00E1000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cap_en,
    input  logic              ch0_frame_start,
    input  logic [9:0]        ch0_fifo_cnt,
    input  logic [DATA_W-1:0] ch0_rd_data,
    output logic              ch0_rd_en,
    input  logic              ch1_frame_start,
    input  logic [9:0]        ch1_fifo_cnt,
    input  logic [DATA_W-1:0] ch1_rd_data,
    output logic              ch1_rd_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              gnt_ch,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    localparam logic [9:0]        BURST_CNT = 10'(BURST_LEN);
    localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BL_A      = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FW_A      = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(CH0_BASE);
    localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(CH1_BASE);

    state_t            state, state_nxt;
    logic              gnt_nxt;
    logic              last_gnt;
    logic [ADDR_W-1:0] off0, off1;
    logic              pend0, pend1;
    logic [7:0]        beat_cnt;
    logic              req0, req1;
    logic              run;
    logic              beat_acc;
    logic              burst_end;
    logic              active0, active1;

    // Next offset after a completed burst, wrapping at the end of the frame
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] off);
        return (off + BL_A == FW_A) ? '0 : off + BL_A;
    endfunction

    assign req0      = cap_en && (ch0_fifo_cnt >= BURST_CNT);
    assign req1      = cap_en && (ch1_fifo_cnt >= BURST_CNT);
    assign run       = !sys_rst;
    assign beat_acc  = wr_valid && wr_ready;
    assign burst_end = beat_acc && wr_last;
    assign active0   = (state != IDLE) && !gnt_ch;
    assign active1   = (state != IDLE) && gnt_ch;

    // Next-state, grant selection and all interface outputs
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_ch;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        ch0_rd_en = 1'b0;
        ch1_rd_en = 1'b0;
        busy      = run && (state != IDLE);
        cmd_len   = LAST_BEAT;
        cmd_addr  = gnt_ch ? (BASE1 + off1) : (BASE0 + off0);
        wr_data   = gnt_ch ? ch1_rd_data : ch0_rd_data;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = CMD;
                    gnt_nxt   = (req0 && req1) ? !last_gnt : req1;
                end
            end
            CMD: begin
                cmd_valid = run;
                if (cmd_ready) state_nxt = DATA;
            end
            DATA: begin
                wr_valid  = run;
                wr_last   = run && (beat_cnt == LAST_BEAT);
                ch0_rd_en = run && wr_ready && !gnt_ch;
                ch1_rd_en = run && wr_ready && gnt_ch;
                if (wr_ready && beat_cnt == LAST_BEAT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and beat counter registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            gnt_ch   <= 1'b0;
            last_gnt <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == CMD) begin
                gnt_ch   <= gnt_nxt;
                last_gnt <= gnt_nxt;
            end
            if (cmd_valid && cmd_ready)
                beat_cnt <= '0;
            else if (beat_acc)
                beat_cnt <= burst_end ? '0 : beat_cnt + 8'd1;
        end
    end

    // Frame offsets: a frame start inside the channel's own burst is deferred
    // to burst end, where it replaces the advance (including one arriving on
    // the final beat itself)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            off0  <= '0;
            off1  <= '0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (burst_end && !gnt_ch) begin
                off0  <= (pend0 || ch0_frame_start) ? '0 : advance(off0);
                pend0 <= 1'b0;
            end else if (ch0_frame_start) begin
                if (active0) pend0 <= 1'b1;
                else         off0  <= '0;
            end
            if (burst_end && gnt_ch) begin
                off1  <= (pend1 || ch1_frame_start) ? '0 : advance(off1);
                pend1 <= 1'b0;
            end else if (ch1_frame_start) begin
                if (active1) pend1 <= 1'b1;
                else         off1  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ov5640_wr_arbiter.sv
// Directed self-checking bench for ov5640_wr_arbiter with a small frame
// (64 words) so offset wrap is reachable, and counting FIFO models.
module tb_ov5640_wr_arbiter;

    localparam logic [27:0] CH0_B = 28'h0000200;
    localparam logic [27:0] CH1_B = 28'h0100000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cap_en;
    logic        ch0_frame_start, ch1_frame_start;
    logic [9:0]  ch0_fifo_cnt, ch1_fifo_cnt;
    logic [31:0] ch0_rd_data, ch1_rd_data;
    logic        ch0_rd_en, ch1_rd_en;
    logic        cmd_valid, cmd_ready;
    logic [27:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready, wr_last;
    logic [31:0] wr_data;
    logic        gnt_ch, busy;

    logic [23:0] ptr0 = '0;
    logic [23:0] ptr1 = '0;
    int          exp_ptr [2];
    int          errors = 0;
    int          checks = 0;

    ov5640_wr_arbiter #(
        .DATA_W(32), .ADDR_W(28), .BURST_LEN(16),
        .CH0_BASE(CH0_B), .CH1_BASE(CH1_B), .FRAME_WORDS(64)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cap_en(cap_en),
        .ch0_frame_start(ch0_frame_start), .ch0_fifo_cnt(ch0_fifo_cnt),
        .ch0_rd_data(ch0_rd_data), .ch0_rd_en(ch0_rd_en),
        .ch1_frame_start(ch1_frame_start), .ch1_fifo_cnt(ch1_fifo_cnt),
        .ch1_rd_data(ch1_rd_data), .ch1_rd_en(ch1_rd_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .gnt_ch(gnt_ch), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // FWFT FIFO heads: tagged incrementing words, popped by rd_en
    assign ch0_rd_data = {8'hA0, ptr0};
    assign ch1_rd_data = {8'hB1, ptr1};
    always @(posedge sys_clk) begin
        if (ch0_rd_en) ptr0 <= ptr0 + 24'd1;
        if (ch1_rd_en) ptr1 <= ptr1 + 24'd1;
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic ch, input int idx);
        return {(ch ? 8'hB1 : 8'hA0), 24'(idx)};
    endfunction

    // One complete burst: command, BURST_LEN beats, then an IDLE cycle
    task automatic run_burst(input logic ch, input logic [27:0] addr, input bit bp, input int fs_beat);
        int n;
        int beats;
        n = 0;
        while (!cmd_valid && n < 20) begin step(); n++; end
        chk("cmd_wait", cmd_valid, 1'b1);
        chk("gnt_ch", gnt_ch, ch);
        chk("cmd_addr", cmd_addr, addr);
        chk("cmd_len", cmd_len, 8'd15);
        chk("busy_cmd", busy, 1'b1);
        beats = 0;
        n = 0;
        while (beats < 16 && n < 80) begin
            step();
            ch0_frame_start = 1'b0;
            if (bp) wr_ready = (n % 2 == 0);
            #1;
            chk("wr_valid", wr_valid, 1'b1);
            chk("wr_last", wr_last, (beats == 15));
            chk("wr_data", wr_data, exp_word(ch, exp_ptr[ch] + beats));
            chk("rd_en_gnt", ch ? ch1_rd_en : ch0_rd_en, wr_ready);
            chk("rd_en_other", ch ? ch0_rd_en : ch1_rd_en, 1'b0);
            if (beats == fs_beat) ch0_frame_start = 1'b1;
            if (wr_ready) beats++;
            n++;
        end
        chk("beat_timeout", beats, 16);
        exp_ptr[ch] += 16;
        step();
        ch0_frame_start = 1'b0;
        wr_ready = 1'b1;
        #1;
        chk("idle_after", busy, 1'b0);
        chk("wr_valid_idle", wr_valid, 1'b0);
    endtask

    initial begin
        int n;
        exp_ptr[0] = 0;
        exp_ptr[1] = 0;
        sys_rst = 1'b1; cap_en = 1'b0;
        ch0_frame_start = 1'b0; ch1_frame_start = 1'b0;
        ch0_fifo_cnt = '0; ch1_fifo_cnt = '0;
        cmd_ready = 1'b1; wr_ready = 1'b1;
        repeat (3) step();
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_last", wr_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt_ch, 1'b0);
        chk("rst_rd_en", {ch1_rd_en, ch0_rd_en}, 2'b00);

        // Below threshold: no request
        sys_rst = 1'b0; cap_en = 1'b1; ch0_fifo_cnt = 10'd15;
        repeat (3) step();
        chk("below_burst_idle", busy, 1'b0);

        // Single channel
        ch0_fifo_cnt = 10'd16;
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, -1);

        // Contention: alternate grants
        ch0_fifo_cnt = 10'd64; ch1_fifo_cnt = 10'd64;
        run_burst(1'b1, CH1_B + 28'd0, 1'b0, -1);
        run_burst(1'b0, CH0_B + 28'd16, 1'b0, -1);
        run_burst(1'b1, CH1_B + 28'd16, 1'b0, -1);
        run_burst(1'b0, CH0_B + 28'd32, 1'b0, -1);

        // cap_en low blocks new grants
        cap_en = 1'b0;
        repeat (3) step();
        chk("cap_en_block", busy, 1'b0);

        // Backpressure, then offset wrap at 64 words
        cap_en = 1'b1; ch1_fifo_cnt = '0;
        run_burst(1'b0, CH0_B + 28'd48, 1'b1, -1);
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, -1);

        // Frame start mid-burst, on the final beat, and while idle
        run_burst(1'b0, CH0_B + 28'd16, 1'b0, 5);
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, 15);
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, -1);
        cap_en = 1'b0;
        step();
        ch0_frame_start = 1'b1;
        step();
        ch0_frame_start = 1'b0;
        cap_en = 1'b1;
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, -1);

        // Reset during the 7th beat aborts the burst
        n = 0;
        while (!cmd_valid && n < 20) begin step(); n++; end
        chk("abort_cmd_addr", cmd_addr, CH0_B + 28'd16);
        for (int i = 0; i < 7; i++) begin
            step();
            #1;
            chk("abort_wr_data", wr_data, exp_word(1'b0, exp_ptr[0] + i));
        end
        sys_rst = 1'b1; ch1_fifo_cnt = 10'd64;
        #1;
        chk("rst_in_burst_rd_en", ch0_rd_en, 1'b0);
        step();
        chk("abort_wr_valid", wr_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cmd_valid", cmd_valid, 1'b0);
        chk("abort_wr_last", wr_last, 1'b0);
        exp_ptr[0] += 6;
        sys_rst = 1'b0;
        run_burst(1'b0, CH0_B + 28'd0, 1'b0, -1);
        run_burst(1'b1, CH1_B + 28'd0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov5640_wr_arbiter.md
OV5640_WR_ARBITER -- requirements
Module: ov5640_wr_arbiter

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 32, pixel-word width.
- ADDR_W, 28, word address width.
- BURST_LEN, 16, words per burst (power of two, 2..256).
- CH0_BASE, 0, channel 0 frame base word address.
- CH1_BASE, 'h0100000, channel 1 frame base word address.
- FRAME_WORDS, 'h00E1000, words per frame (multiple of BURST_LEN).

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- sys_clk, in, 1: single clock; all logic is on its rising edge.
- sys_rst, in, 1: synchronous active-high reset.
- cap_en, in, 1: capture enable, normally tied to cmos_init_done.
- chN_frame_start, in, 1 (N=0,1): one-cycle pulse per frame; sys_clk domain.
- chN_fifo_cnt, in, 10: words held in that channel's line FIFO.
- chN_rd_data, in, DATA_W: first-word-fall-through FIFO head.
- chN_rd_en, out, 1: FIFO pop.
- cmd_valid, out, 1: burst command valid.
- cmd_ready, in, 1: burst command ready.
- cmd_addr, out, ADDR_W: burst start word address.
- cmd_len, out, 8: constant BURST_LEN-1.
- wr_valid, out, 1: write beat valid.
- wr_ready, in, 1: write beat ready.
- wr_data, out, DATA_W: write beat data.
- wr_last, out, 1: final beat of a burst.
- gnt_ch, out, 1: granted channel.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 The block SHALL implement the FSM IDLE -> CMD -> DATA -> IDLE, with no other states.
REQ-004 chN SHALL be requesting when cap_en=1 and chN_fifo_cnt >= BURST_LEN.
REQ-005 In IDLE with at least one requester, the block SHALL register gnt_ch and enter CMD on the next edge; cmd_valid SHALL be high exactly while in CMD.
REQ-006 Arbitration SHALL be round-robin: with both channels requesting, the grant goes to the channel not granted last; after reset, ch0 has priority.
REQ-007 cmd_addr SHALL equal base(gnt_ch) + offset(gnt_ch) and SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-008 On cmd_valid and cmd_ready both high, the FSM SHALL enter DATA; the burst count SHALL be 0.
REQ-009 In DATA, wr_valid SHALL be 1 and wr_data SHALL equal ch<gnt_ch>_rd_data combinationally.
REQ-010 ch<gnt_ch>_rd_en SHALL equal wr_valid AND wr_ready; the other channel's rd_en SHALL be 0.
REQ-011 The beat counter SHALL increment on each accepted beat; wr_last SHALL be high when count = BURST_LEN-1.
REQ-012 On the accepted beat with wr_last=1, the FSM SHALL return to IDLE and offset(gnt_ch) SHALL advance by BURST_LEN.
REQ-013 If offset+BURST_LEN = FRAME_WORDS, the offset SHALL wrap to 0.
REQ-014 IDLE SHALL last at least one cycle between bursts. Minimum burst overhead is 2 cycles: IDLE, then CMD with immediate cmd_ready.
REQ-015 chN_frame_start SHALL clear offset(N) to 0 on the next edge when channel N is not in an active CMD/DATA burst.
REQ-016 If channel N is in an active CMD/DATA burst, chN_frame_start SHALL set pend(N); the clear SHALL then apply instead of the advance at burst end, and pend(N) SHALL be cleared.
REQ-017 A frame_start coinciding with that channel's final accepted beat SHALL be handled as pending, giving offset 0.
REQ-018 Deasserting cap_en SHALL block new grants only; a burst already in CMD or DATA SHALL complete.
REQ-019 wr_valid SHALL never drop mid-burst; backpressure SHALL be exclusively through wr_ready.
REQ-020 Beats SHALL be issued only with FIFO data guaranteed by REQ-004. No underflow check is required.

Reset
REQ-021 While sys_rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear the offsets, pend flags and beat counter;
- set the last-grant pointer so that ch0 wins first;
- drive gnt_ch=0.
REQ-022 While in reset, cmd_valid, wr_valid, wr_last, chN_rd_en and busy SHALL be 0.
REQ-023 Reset asserted mid-burst SHALL abort the burst immediately, with no further beats and no offset advance.

Verification
REQ-024 Single channel: ch0_fifo_cnt=16, cap_en=1, cmd_ready=1, wr_ready=1 -> cmd_addr=CH0_BASE; 16 beats; wr_last on the 16th; ch0 offset becomes 16.
REQ-025 Contention: both counts at 64 held -> grants alternate 0,1,0,1; ch1 addresses are CH1_BASE+0, +16, ...
REQ-026 Backpressure: wr_ready toggles 1,0 per cycle -> 16 beats over 32 cycles; rd_en pulses only on accepted beats; wr_data matches FIFO order.
REQ-027 Frame start mid-burst: ch0_frame_start at beat 5 of the 3rd ch0 burst -> next ch0 cmd_addr=CH0_BASE.
REQ-028 Wrap: FRAME_WORDS=64, 5 ch0 bursts -> addresses 0, 16, 32, 48, 0.
REQ-029 Reset at beat 7 -> outputs 0 the next cycle; the following burst starts at CH0_BASE with a ch0 grant.
